// File: rtl/alu_p_register_patdet.sv
// P output register stage for the 48-bit three-operand ALU.
// It registers the ALU sum and carry-out under a clock enable.
// It also detects a masked pattern and its complement on the sum.
// From those flags it derives overflow/underflow.
// It can clear P automatically when a pattern event occurs.
module alu_p_register_patdet #(
  parameter int WIDTH            = 48,
  parameter int AUTORESET_PATDET = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             CEP,
  input  logic             RSTP,
  input  logic [WIDTH-1:0] S,
  input  logic             COUT,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [WIDTH-1:0] MASK,
  output logic [WIDTH-1:0] P,
  output logic             CARRYOUT,
  output logic             PATTERNDETECT,
  output logic             PATTERNBDETECT,
  output logic             PATTERNDETECTPAST,
  output logic             PATTERNBDETECTPAST,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  // Masked equality: a MASK bit of 1 removes that bit from the compare.
  function automatic logic f_masked_match(
    input logic [WIDTH-1:0] value,
    input logic [WIDTH-1:0] ref_value,
    input logic [WIDTH-1:0] mask
  );
    f_masked_match = &(~(value ^ ref_value) | mask);
  endfunction

  logic [WIDTH-1:0] r_p;
  logic             r_carry;
  logic             r_pd;
  logic             r_pbd;
  logic             r_pd_past;
  logic             r_pbd_past;

  logic             w_pd_n;
  logic             w_pbd_n;
  logic             w_mode_match;
  logic             w_mode_loss;
  logic             w_autoreset;

  assign w_pd_n  = f_masked_match(S, PATTERN, MASK);
  assign w_pbd_n = f_masked_match(S, ~PATTERN, MASK);

  // Only modes 1 and 2 can trigger a clear.
  // Any other parameter value leaves both mode selects low, so it acts as mode 0.
  assign w_mode_match = (AUTORESET_PATDET == 1);
  assign w_mode_loss  = (AUTORESET_PATDET == 2);

  // The autoreset decision uses the registered flags.
  // So the clear lands one enabled edge after the event becomes visible on the outputs.
  assign w_autoreset = CEP & ((w_mode_match & r_pd) |
                              (w_mode_loss & r_pd_past & ~r_pd));

  // P / carry / pattern flag registers.
  // Priority: RSTP first, then autoreset, then the enabled capture; otherwise the registers hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p        <= '0;
      r_carry    <= 1'b0;
      r_pd       <= 1'b0;
      r_pbd      <= 1'b0;
      r_pd_past  <= 1'b0;
      r_pbd_past <= 1'b0;
    end else if (RSTP) begin
      r_p        <= '0;
      r_carry    <= 1'b0;
      r_pd       <= 1'b0;
      r_pbd      <= 1'b0;
      r_pd_past  <= 1'b0;
      r_pbd_past <= 1'b0;
    end else if (w_autoreset) begin
      // The sum presented on this edge is dropped.
      // The flags still track it so that pattern history stays continuous.
      r_p        <= '0;
      r_carry    <= 1'b0;
      r_pd       <= w_pd_n;
      r_pbd      <= w_pbd_n;
      r_pd_past  <= r_pd;
      r_pbd_past <= r_pbd;
    end else if (CEP) begin
      r_p        <= S;
      r_carry    <= COUT;
      r_pd       <= w_pd_n;
      r_pbd      <= w_pbd_n;
      r_pd_past  <= r_pd;
      r_pbd_past <= r_pbd;
    end else begin
      r_p        <= r_p;
      r_carry    <= r_carry;
      r_pd       <= r_pd;
      r_pbd      <= r_pbd;
      r_pd_past  <= r_pd_past;
      r_pbd_past <= r_pbd_past;
    end
  end

  assign P                  = r_p;
  assign CARRYOUT           = r_carry;
  assign PATTERNDETECT      = r_pd;
  assign PATTERNBDETECT     = r_pbd;
  assign PATTERNDETECTPAST  = r_pd_past;
  assign PATTERNBDETECTPAST = r_pbd_past;

  // A match that was held last cycle has now been lost in the positive or negative direction.
  // With MASK all-ones both current flags stay set, so neither output can assert.
  assign OVERFLOW  = r_pd_past  & ~r_pd & ~r_pbd;
  assign UNDERFLOW = r_pbd_past & ~r_pd & ~r_pbd;

endmodule

// File: tb/tb_alu_p_register_patdet.sv
// Directed bench for alu_p_register_patdet.
// Three instances share the stimulus and differ only in autoreset mode (0, 1, 2).
module tb_alu_p_register_patdet;

  localparam int W = 48;

  logic         clk;
  logic         reset_n;
  logic         cep;
  logic         rstp;
  logic [W-1:0] s;
  logic         cout;
  logic [W-1:0] pattern;
  logic [W-1:0] mask;

  logic [W-1:0] p0, p1, p2;
  logic co0, co1, co2;
  logic pd0, pd1, pd2;
  logic pbd0, pbd1, pbd2;
  logic pdp0, pdp1, pdp2;
  logic pbdp0, pbdp1, pbdp2;
  logic ov0, ov1, ov2;
  logic un0, un1, un2;

  int vectors;
  int miscompares;

  alu_p_register_patdet #(.WIDTH(W), .AUTORESET_PATDET(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .CEP(cep), .RSTP(rstp), .S(s), .COUT(cout),
    .PATTERN(pattern), .MASK(mask), .P(p0), .CARRYOUT(co0), .PATTERNDETECT(pd0),
    .PATTERNBDETECT(pbd0), .PATTERNDETECTPAST(pdp0), .PATTERNBDETECTPAST(pbdp0),
    .OVERFLOW(ov0), .UNDERFLOW(un0));

  alu_p_register_patdet #(.WIDTH(W), .AUTORESET_PATDET(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .CEP(cep), .RSTP(rstp), .S(s), .COUT(cout),
    .PATTERN(pattern), .MASK(mask), .P(p1), .CARRYOUT(co1), .PATTERNDETECT(pd1),
    .PATTERNBDETECT(pbd1), .PATTERNDETECTPAST(pdp1), .PATTERNBDETECTPAST(pbdp1),
    .OVERFLOW(ov1), .UNDERFLOW(un1));

  alu_p_register_patdet #(.WIDTH(W), .AUTORESET_PATDET(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .CEP(cep), .RSTP(rstp), .S(s), .COUT(cout),
    .PATTERN(pattern), .MASK(mask), .P(p2), .CARRYOUT(co2), .PATTERNDETECT(pd2),
    .PATTERNBDETECT(pbd2), .PATTERNDETECTPAST(pdp2), .PATTERNBDETECTPAST(pbdp2),
    .OVERFLOW(ov2), .UNDERFLOW(un2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n = 1'b0;
    cep     = 1'b1;
    rstp    = 1'b0;
    s       = 48'h0000_0000_1234;
    cout    = 1'b0;
    pattern = 48'h0;
    mask    = 48'h0;

    // Reset holds everything at zero even with CEP high.
    tick(); tick();
    check("rst_p", p0, 48'h0);
    check("rst_co", {47'h0, co0}, 48'h0);
    check("rst_flags", {44'h0, pd0, pbd0, pdp0, pbdp0}, 48'h0);
    check("rst_ovun", {46'h0, ov0, un0}, 48'h0);

    // Release reset with the enable low: P must not load.
    reset_n = 1'b1;
    cep     = 1'b0;
    tick(); tick(); tick();
    check("hold_p", p0, 48'h0);
    cep = 1'b1;
    tick();
    check("load_p", p0, 48'h0000_0000_1234);

    // All-ones sum with a carry; it also equals ~PATTERN, so PBD asserts.
    s    = 48'hFFFF_FFFF_FFFF;
    cout = 1'b1;
    tick();
    check("lat_p", p0, 48'hFFFF_FFFF_FFFF);
    check("lat_co", {47'h0, co0}, 48'h1);
    check("lat_pd_pbd", {46'h0, pd0, pbd0}, 48'h1);

    // RSTP wins over CEP.
    rstp = 1'b1;
    tick();
    check("rstp_p", p0, 48'h0);
    check("rstp_co_flags", {43'h0, co0, pd0, pbd0, pdp0, pbdp0}, 48'h0);
    rstp = 1'b0;
    cout = 1'b0;

    // Masked compare: the low 16 bits are ignored.
    mask = 48'h0000_0000_FFFF;
    s    = 48'h0000_0000_ABCD;
    tick();
    check("mask_match", {46'h0, pd0, pbd0}, 48'h2);
    s = 48'h0001_0000_0000;
    tick();
    check("mask_nomatch", {46'h0, pd0, pbd0}, 48'h0);
    check("mask_ovf", {46'h0, ov0, un0}, 48'h2);
    check("m1_clear_after_match", p1, 48'h0);
    check("m2_no_clear_yet", p2, 48'h0001_0000_0000);

    // Overflow sequence.
    // The mode-2 instance clears on this first edge because its match was lost.
    mask = 48'h0000_7FFF_FFFF;
    s    = 48'h0000_0000_0010;
    tick();
    check("ovf_acc1_p", p0, 48'h0000_0000_0010);
    check("ovf_acc1_pd", {47'h0, pd0}, 48'h1);
    check("m2_clear_after_loss", p2, 48'h0);
    s = 48'h0000_8000_0000;
    tick();
    check("ovf_flags", {45'h0, pd0, pdp0, ov0}, 48'h3);
    check("ovf_un", {47'h0, un0}, 48'h0);

    // Underflow sequence.
    s = 48'hFFFF_FFFF_FFF0;
    tick();
    check("unf_step1", {44'h0, pd0, pbd0, ov0, un0}, 48'h4);
    s = 48'hFFFF_7FFF_FFFF;
    tick();
    check("unf_flags", {44'h0, pbd0, pbdp0, ov0, un0}, 48'h5);

    // Autoreset mode 1: clear P on the edge after a match.
    rstp = 1'b1;
    tick();
    rstp    = 1'b0;
    pattern = 48'd5;
    mask    = 48'h0;
    s       = 48'd5;
    tick();
    check("m1_match_p", p1, 48'd5);
    check("m1_match_pd", {47'h0, pd1}, 48'h1);
    s = 48'd9;
    tick();
    check("m1_cleared", p1, 48'h0);
    check("m0_not_cleared", p0, 48'd9);
    s = 48'd5;
    tick();
    check("m1_rematch", p1, 48'd5);
    cep = 1'b0;
    s   = 48'd9;
    tick();
    check("m1_cep0_hold", p1, 48'd5);
    cep = 1'b1;
    tick();
    check("m1_cep1_clear", p1, 48'h0);

    // Priority: RSTP and autoreset on the same edge clear everything, including PAST.
    s = 48'd5;
    tick();
    tick();
    check("prio_pre_past", {46'h0, pd1, pdp1}, 48'h3);
    rstp = 1'b1;
    tick();
    check("prio_flags", {44'h0, pd1, pbd1, pdp1, pbdp1}, 48'h0);
    check("prio_p", p1, 48'h0);
    rstp = 1'b0;

    // Asynchronous reset between edges.
    s = 48'h0000_0000_0077;
    tick();
    check("async_pre", p0, 48'h0000_0000_0077);
    #2 reset_n = 1'b0;
    #1;
    check("async_p0", p0, 48'h0);
    check("async_p1", p1, 48'h0);
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
